// File: rtl/hazard_unit_if.sv
// Decode-stage hazard interface: IF/ID and ID/EX hazard inputs, stall controls and mul/div status.
// The pipeline control side uses the master modport, and the hazard unit uses the slave modport.
interface hazard_unit_if;
    logic [4:0] IFIDRs;
    logic [4:0] IFIDRt;
    logic [4:0] IFIDRd;
    logic       IFIDLongOp;
    logic [4:0] IDEXRt;
    logic       IDEXMemRead;
    logic       PCWrite;
    logic       IFIDWrite;
    logic       IDEXBubble;
    logic       MDBusy;
    logic       MDDone;
    logic [4:0] MDWriteRd;

    modport master (
        output IFIDRs, IFIDRt, IFIDRd, IFIDLongOp, IDEXRt, IDEXMemRead,
        input  PCWrite, IFIDWrite, IDEXBubble, MDBusy, MDDone, MDWriteRd
    );

    modport slave (
        input  IFIDRs, IFIDRt, IFIDRd, IFIDLongOp, IDEXRt, IDEXMemRead,
        output PCWrite, IFIDWrite, IDEXBubble, MDBusy, MDDone, MDWriteRd
    );
endinterface

// File: rtl/hazard_unit.sv
// Load-use and mul/div hazard detection with an in-flight mul/div latency tracker.
// Define HAZARD_STALL_COUNT_EN to add the saturating StallCount port.
module hazard_unit #(
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    hazard_unit_if.slave  hz
`ifdef HAZARD_STALL_COUNT_EN
    ,
    output logic [15:0]   StallCount
`endif
);
    localparam logic [3:0] LAT = 4'(MULDIV_LAT);

    logic [3:0] cnt_q, cnt_d;
    logic [4:0] pend_rd_q, pend_rd_d;
    logic [4:0] done_rd_q, done_rd_d;
    logic       md_done_q, md_done_d;
    logic       load_use, raw_md, struct_md, stall, issue;

    always_comb begin
        load_use  = hz.IDEXMemRead && (hz.IDEXRt != '0) &&
                    ((hz.IDEXRt == hz.IFIDRs) || (hz.IDEXRt == hz.IFIDRt));
        raw_md    = (cnt_q != '0) && (pend_rd_q != '0) &&
                    ((pend_rd_q == hz.IFIDRs) || (pend_rd_q == hz.IFIDRt));
        struct_md = hz.IFIDLongOp && (cnt_q > 4'd1);
        stall     = load_use || raw_md || struct_md;
        issue     = hz.IFIDLongOp && !stall;
    end

    assign hz.PCWrite    = reset_n && !stall;
    assign hz.IFIDWrite  = reset_n && !stall;
    assign hz.IDEXBubble = !reset_n || stall;
    assign hz.MDBusy     = (cnt_q != '0);
    assign hz.MDDone     = md_done_q;
    assign hz.MDWriteRd  = md_done_q ? done_rd_q : pend_rd_q;

    // The completing destination moves to done_rd so that a reload at cnt==1 can overwrite pend_rd.
    always_comb begin
        cnt_d     = cnt_q;
        pend_rd_d = pend_rd_q;
        done_rd_d = done_rd_q;
        md_done_d = (cnt_q == 4'd1);
        if (cnt_q == 4'd1) begin
            done_rd_d = pend_rd_q;
        end
        if (issue) begin
            cnt_d     = LAT;
            pend_rd_d = hz.IFIDRd;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            pend_rd_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            pend_rd_q <= '0;
            done_rd_q <= '0;
            md_done_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pend_rd_q <= pend_rd_d;
            done_rd_q <= done_rd_d;
            md_done_q <= md_done_d;
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
`endif
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Decode-stage hazard detection and stall control for the 5-stage pipelined CPU. It produces the pipeline-hold and bubble controls that the forwarding path cannot resolve: load-use hazards, and register and structural hazards against the multi-cycle multiply/divide unit. It tracks the in-flight mul/div destination with a latency counter and reports completion to writeback and forwarding. It sits between the IF/ID register, the ID/EX register and the mul/div unit.

## Interface
- MULDIV_LAT, 4: cycles from mul/div issue to result write; legal range 1..15.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- IFIDRs  in  5  decode-stage source register 1.
- IFIDRt  in  5  decode-stage source register 2.
- IFIDRd  in  5  decode-stage destination register.
- IFIDLongOp  in  1  decode instruction is a mul/div.
- IDEXRt  in  5  load destination in the EX stage.
- IDEXMemRead  in  1  EX-stage instruction is a load.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register load enable.
- IDEXBubble  out  1  zero the ID/EX control fields this cycle.
- MDBusy  out  1  mul/div counter is non-zero.
- MDDone  out  1  one-cycle pulse: mul/div result written; MDWriteRd is valid.
- MDWriteRd  out  5  destination of the completing or in-flight mul/div.
- StallCount  out  16  total stall cycles. Present only when HAZARD_STALL_COUNT_EN is defined.

## Operation
- State: `cnt` (4 bits), `pendRd` (5 bits), `MDDone` register.
- loadUse = IDEXMemRead && IDEXRt!=0 && (IDEXRt==IFIDRs || IDEXRt==IFIDRt).
- rawMD = cnt!=0 && pendRd!=0 && (pendRd==IFIDRs || pendRd==IFIDRt).
- structMD = IFIDLongOp && cnt>1.
- stall = loadUse || rawMD || structMD.
- Outputs during a stall: PCWrite=0, IFIDWrite=0, IDEXBubble=1. Without a stall: 1, 1, 0.
- Issue: IFIDLongOp && !stall. On that clock edge, cnt <= MULDIV_LAT and pendRd <= IFIDRd. Destination 0 is tracked for timing only; it never causes a RAW stall.
- Countdown: when cnt!=0 and no issue occurs, cnt decrements by 1 each edge.
- On the edge where cnt goes 1->0, MDDone is set for the following cycle. pendRd is held through that cycle (drives MDWriteRd) and cleared on the next edge unless a new issue occurs.
- MDBusy = (cnt!=0).
- Issue when cnt==1 is legal: completion of the old op (MDDone pulse) and reload happen on the same edge. pendRd takes the new destination. MDWriteRd for the completing op is captured into a separate completion register, so it is not lost.
- Simultaneous hazards: stall is a single OR of the three conditions. A long op held by loadUse is not issued and cnt is not reloaded.

## Timing
- stall, PCWrite, IFIDWrite and IDEXBubble are combinational from the current inputs and state, with zero-cycle latency.
- cnt, pendRd, MDDone, the completion register and StallCount are registered on the clk rising edge.
- A dependent instruction directly behind a mul/div stalls MULDIV_LAT cycles. It proceeds in the cycle MDDone is high, and the forwarding path supplies the value.
- A load-use hazard stalls exactly 1 cycle.
- Reset (reset_n=0, asynchronous):
  - cnt=0, pendRd=0, completion register=0, MDDone=0, StallCount=0.
  - Combinational outputs are forced to PCWrite=0, IFIDWrite=0, IDEXBubble=1 while reset is asserted.
  - MDBusy=0, MDWriteRd=0.
- Reset mid-operation abandons the in-flight mul/div with no MDDone pulse.
- The first edge after deassertion behaves as normal operation.

## Configuration
- HAZARD_STALL_COUNT_EN defined:
  - StallCount port and register are present.
  - The counter increments on every edge where stall=1 and reset_n=1.
  - It saturates at 16'hFFFF.
- HAZARD_STALL_COUNT_EN undefined: the port and register are absent. Stall behaviour is identical.

## Test plan
- Load-use: IDEXMemRead=1, IDEXRt=5, IFIDRs=5 -> PCWrite=0, IFIDWrite=0, IDEXBubble=1 for 1 cycle. Repeat with IDEXRt=0 -> no stall.
- Mul/div RAW: MULDIV_LAT=4, issue with IFIDRd=8, next instruction IFIDRt=8 -> 4 stall cycles, MDDone=1 with MDWriteRd=8 in the release cycle, then PCWrite=1.
- Structural: second IFIDLongOp while cnt=3 -> stalls until cnt==1, issues on that edge, MDDone pulses for the first op with the correct MDWriteRd.
- Simultaneous: loadUse and structMD both true -> a single stall and no cnt reload. After the hazard clears, issue proceeds normally.
- Reset mid-op: reset_n low while cnt=2 -> cnt=0, MDBusy=0 and outputs forced (0, 0, 1) asynchronously; no MDDone after release.
- With HAZARD_STALL_COUNT_EN: the above sequence gives StallCount equal to the total stall cycles. A forced value of 16'hFFFF plus one more stall stays at 16'hFFFF.
